// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared types for the writeback arbiter.
//   ROB_W / PHYS_W : ROB index and physical register index widths.
//   wb_src_e       : writeback source index (ALU=0, BRU=1, LSU=2).
//   fu_wb_t        : one merged writeback packet for ROB, PRF and RS wakeup.
//   next_src       : round-robin successor of a source, modulo 3.
package wb_arbiter_pkg;

    localparam int ROB_W  = 6;
    localparam int PHYS_W = 7;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_BRU = 2'd1,
        SRC_LSU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_idx;
        logic [PHYS_W-1:0] prd_new;
        logic [31:0]       data;
        logic              data_valid;     // result writes a destination register
        logic [1:0]        epoch;
        logic [31:0]       pc;
        logic              act_taken;      // BRU sideband, zero for ALU/LSU packets
        logic              mispredict;
        logic              redirect_valid;
        logic [31:0]       redirect_pc;
    } fu_wb_t;

    function automatic wb_src_e next_src(input wb_src_e s);
        case (s)
            SRC_ALU: next_src = SRC_BRU;
            SRC_BRU: next_src = SRC_LSU;
            default: next_src = SRC_ALU;
        endcase
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_arb3.sv
// rr_arb3: combinational 3-way round-robin grant.
//   req [2:0] : request vector, bit i = source i.
//   ptr [1:0] : highest-priority source this cycle (0..2).
//   gnt [2:0] : one-hot grant, the first requester at or after ptr (wrapping).
module rr_arb3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        case (ptr)
            2'd1: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd2: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the ALU, BRU and LSU writeback streams into one
// registered fu_wb_t packet per cycle, with round-robin fairness, BRU
// branch sideband and stale-epoch discard.
//   clk, rst_n                    : clock, asynchronous active-low reset.
//   {alu,bru,lsu}_wb_*            : source packet (valid/ready + payload).
//   bru_act_taken .. redirect_pc  : BRU sideband, qualified by bru_wb_valid.
//   flush_valid                   : full flush, drops the buffered packet.
//   recover_valid/recover_epoch   : mispredict recovery, new current epoch.
//   wb_valid/wb_ready/wb_pkt      : registered output towards ROB/PRF/RS.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Sources hold their packet stable until ready; ready may depend
// combinationally on valid. wb_pkt is held stable while wb_valid && !wb_ready.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ROB_W  = wb_arbiter_pkg::ROB_W,
    parameter int PHYS_W = wb_arbiter_pkg::PHYS_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              alu_wb_valid,
    output logic              alu_wb_ready,
    input  logic [ROB_W-1:0]  alu_wb_rob_idx,
    input  logic [PHYS_W-1:0] alu_wb_prd_new,
    input  logic [31:0]       alu_wb_data,
    input  logic [1:0]        alu_wb_epoch,
    input  logic              alu_wb_uses_rd,
    input  logic [31:0]       alu_wb_pc,

    input  logic              bru_wb_valid,
    output logic              bru_wb_ready,
    input  logic [ROB_W-1:0]  bru_wb_rob_idx,
    input  logic [PHYS_W-1:0] bru_wb_prd_new,
    input  logic [31:0]       bru_wb_data,
    input  logic [1:0]        bru_wb_epoch,
    input  logic              bru_wb_uses_rd,
    input  logic [31:0]       bru_wb_pc,

    input  logic              lsu_wb_valid,
    output logic              lsu_wb_ready,
    input  logic [ROB_W-1:0]  lsu_wb_rob_idx,
    input  logic [PHYS_W-1:0] lsu_wb_prd_new,
    input  logic [31:0]       lsu_wb_data,
    input  logic [1:0]        lsu_wb_epoch,
    input  logic              lsu_wb_uses_rd,
    input  logic [31:0]       lsu_wb_pc,

    input  logic              bru_act_taken,
    input  logic              bru_mispredict,
    input  logic              bru_redirect_valid,
    input  logic [31:0]       bru_redirect_pc,

    input  logic              flush_valid,
    input  logic              recover_valid,
    input  logic [1:0]        recover_epoch,

    output logic              wb_valid,
    input  logic              wb_ready,
    output fu_wb_t            wb_pkt
);

    logic [2:0] src_v;
    logic [2:0] stale;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [2:0] src_ready;
    fu_wb_t     src_pkt [3];
    fu_wb_t     sel_pkt;
    wb_src_e    gnt_src;

    logic       out_v;
    fu_wb_t     out_pkt;
    wb_src_e    rr_ptr;
    logic [1:0] cur_epoch;
    logic [1:0] eff_epoch;
    logic       cap_ok;
    logic       cap;

    assign src_v = {lsu_wb_valid, bru_wb_valid, alu_wb_valid};

    // Per-source packets; only the BRU packet carries branch sideband.
    always_comb begin
        src_pkt[0]            = '0;
        src_pkt[0].rob_idx    = alu_wb_rob_idx;
        src_pkt[0].prd_new    = alu_wb_prd_new;
        src_pkt[0].data       = alu_wb_data;
        src_pkt[0].data_valid = alu_wb_uses_rd;
        src_pkt[0].epoch      = alu_wb_epoch;
        src_pkt[0].pc         = alu_wb_pc;

        src_pkt[1]                = '0;
        src_pkt[1].rob_idx        = bru_wb_rob_idx;
        src_pkt[1].prd_new        = bru_wb_prd_new;
        src_pkt[1].data           = bru_wb_data;
        src_pkt[1].data_valid     = bru_wb_uses_rd;
        src_pkt[1].epoch          = bru_wb_epoch;
        src_pkt[1].pc             = bru_wb_pc;
        src_pkt[1].act_taken      = bru_act_taken;
        src_pkt[1].mispredict     = bru_mispredict;
        src_pkt[1].redirect_valid = bru_redirect_valid;
        src_pkt[1].redirect_pc    = bru_redirect_pc;

        src_pkt[2]            = '0;
        src_pkt[2].rob_idx    = lsu_wb_rob_idx;
        src_pkt[2].prd_new    = lsu_wb_prd_new;
        src_pkt[2].data       = lsu_wb_data;
        src_pkt[2].data_valid = lsu_wb_uses_rd;
        src_pkt[2].epoch      = lsu_wb_epoch;
        src_pkt[2].pc         = lsu_wb_pc;
    end

    // During recovery the incoming epoch is already the current one, so a
    // packet from the new epoch can be granted in the recovery cycle itself.
    assign eff_epoch = recover_valid ? recover_epoch : cur_epoch;

    always_comb begin
        stale = '0;
        for (int i = 0; i < 3; i++) begin
            stale[i] = src_v[i] & (src_pkt[i].epoch != eff_epoch);
        end
    end

    assign req = src_v & ~stale;

    rr_arb3 u_rr_arb3 (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign cap_ok = ~out_v | wb_ready;
    assign cap    = ~flush_valid & cap_ok & (|req);

    // Stale packets are sunk without a grant, even when the output is full.
    assign src_ready = {3{rst_n & ~flush_valid}} & (stale | (gnt & {3{cap_ok}}));

    assign alu_wb_ready = src_ready[0];
    assign bru_wb_ready = src_ready[1];
    assign lsu_wb_ready = src_ready[2];

    always_comb begin
        sel_pkt = '0;
        gnt_src = SRC_ALU;
        if (gnt[1]) begin
            sel_pkt = src_pkt[1];
            gnt_src = SRC_BRU;
        end else if (gnt[2]) begin
            sel_pkt = src_pkt[2];
            gnt_src = SRC_LSU;
        end else if (gnt[0]) begin
            sel_pkt = src_pkt[0];
            gnt_src = SRC_ALU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v     <= 1'b0;
            out_pkt   <= '0;
            rr_ptr    <= SRC_ALU;
            cur_epoch <= 2'd0;
        end else begin
            if (recover_valid) begin
                cur_epoch <= recover_epoch;
            end
            if (flush_valid) begin
                out_v <= 1'b0;
            end else if (cap) begin
                out_v   <= 1'b1;
                out_pkt <= sel_pkt;
                rr_ptr  <= next_src(gnt_src);
            end else if (wb_ready && out_v) begin
                out_v <= 1'b0;
            end else if (recover_valid && (out_pkt.epoch != recover_epoch)) begin
                out_v <= 1'b0;
            end
        end
    end

    assign wb_valid = out_v;
    assign wb_pkt   = out_pkt;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic              s_v    [3];
    logic [ROB_W-1:0]  s_rob  [3];
    logic [PHYS_W-1:0] s_prd  [3];
    logic [31:0]       s_data [3];
    logic [1:0]        s_ep   [3];
    logic              s_rd   [3];
    logic [31:0]       s_pc   [3];

    logic        bru_act_taken, bru_mispredict, bru_redirect_valid;
    logic [31:0] bru_redirect_pc;
    logic        flush_valid, recover_valid;
    logic [1:0]  recover_epoch;
    logic        wb_ready;

    logic        alu_wb_ready, bru_wb_ready, lsu_wb_ready;
    logic        wb_valid;
    fu_wb_t      wb_pkt;
    logic [2:0]  dut_rdy;
    assign dut_rdy = {lsu_wb_ready, bru_wb_ready, alu_wb_ready};

    int checks   = 0;
    int failures = 0;

    wb_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .alu_wb_valid       (s_v[0]),
        .alu_wb_ready       (alu_wb_ready),
        .alu_wb_rob_idx     (s_rob[0]),
        .alu_wb_prd_new     (s_prd[0]),
        .alu_wb_data        (s_data[0]),
        .alu_wb_epoch       (s_ep[0]),
        .alu_wb_uses_rd     (s_rd[0]),
        .alu_wb_pc          (s_pc[0]),
        .bru_wb_valid       (s_v[1]),
        .bru_wb_ready       (bru_wb_ready),
        .bru_wb_rob_idx     (s_rob[1]),
        .bru_wb_prd_new     (s_prd[1]),
        .bru_wb_data        (s_data[1]),
        .bru_wb_epoch       (s_ep[1]),
        .bru_wb_uses_rd     (s_rd[1]),
        .bru_wb_pc          (s_pc[1]),
        .lsu_wb_valid       (s_v[2]),
        .lsu_wb_ready       (lsu_wb_ready),
        .lsu_wb_rob_idx     (s_rob[2]),
        .lsu_wb_prd_new     (s_prd[2]),
        .lsu_wb_data        (s_data[2]),
        .lsu_wb_epoch       (s_ep[2]),
        .lsu_wb_uses_rd     (s_rd[2]),
        .lsu_wb_pc          (s_pc[2]),
        .bru_act_taken      (bru_act_taken),
        .bru_mispredict     (bru_mispredict),
        .bru_redirect_valid (bru_redirect_valid),
        .bru_redirect_pc    (bru_redirect_pc),
        .flush_valid        (flush_valid),
        .recover_valid      (recover_valid),
        .recover_epoch      (recover_epoch),
        .wb_valid           (wb_valid),
        .wb_ready           (wb_ready),
        .wb_pkt             (wb_pkt)
    );

    // ---------------- behavioural model ----------------
    // State: is a packet buffered, what it holds, whose turn it is, which
    // epoch is live. Everything else is derived from the rules each cycle.
    logic       m_out_v;
    fu_wb_t     m_pkt;
    int         m_rr;
    logic [1:0] m_epoch;

    function automatic fu_wb_t mk_pkt(input int g);
        fu_wb_t p;
        p            = '0;
        p.rob_idx    = s_rob[g];
        p.prd_new    = s_prd[g];
        p.data       = s_data[g];
        p.data_valid = s_rd[g];
        p.epoch      = s_ep[g];
        p.pc         = s_pc[g];
        if (g == 1) begin
            p.act_taken      = bru_act_taken;
            p.mispredict     = bru_mispredict;
            p.redirect_valid = bru_redirect_valid;
            p.redirect_pc    = bru_redirect_pc;
        end
        return p;
    endfunction

    function automatic void model_eval(output logic [2:0] rdy, output int g, output logic cap);
        logic [1:0] live;
        logic       room;
        int         idx;
        rdy  = '0;
        g    = -1;
        cap  = 1'b0;
        if (!rst_n) return;
        live = recover_valid ? recover_epoch : m_epoch;
        room = !m_out_v || wb_ready;
        for (int k = 0; k < 3; k++) begin
            idx = (m_rr + k) % 3;
            if (g < 0 && s_v[idx] && s_ep[idx] == live) g = idx;
        end
        for (int j = 0; j < 3; j++) begin
            if (s_v[j] && s_ep[j] != live) rdy[j] = 1'b1;
        end
        if (g >= 0 && room) rdy[g] = 1'b1;
        if (flush_valid) rdy = '0;
        cap = (g >= 0) && room && !flush_valid;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_upd
        logic [2:0] r;
        int         g;
        logic       c;
        if (!rst_n) begin
            m_out_v <= 1'b0;
            m_pkt   <= '0;
            m_rr    <= 0;
            m_epoch <= 2'd0;
        end else begin
            model_eval(r, g, c);
            if (recover_valid) m_epoch <= recover_epoch;
            if (flush_valid) begin
                m_out_v <= 1'b0;
            end else if (c) begin
                m_out_v <= 1'b1;
                m_pkt   <= mk_pkt(g);
                m_rr    <= (g + 1) % 3;
            end else if (m_out_v && wb_ready) begin
                m_out_v <= 1'b0;
            end else if (recover_valid && m_pkt.epoch != recover_epoch) begin
                m_out_v <= 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: compare DUT against the model on the falling edge, then
    // advance past the rising edge and retire any source the DUT accepted.
    task automatic tick();
        logic [2:0] er;
        int         g;
        logic       c;
        logic [2:0] taken;
        @(negedge clk);
        model_eval(er, g, c);
        chk("model_readies", dut_rdy, er);
        chk("model_wb_valid", wb_valid, m_out_v);
        checks++;
        if (wb_pkt !== m_pkt) begin
            failures++;
            $display("FAIL model_wb_pkt: got %h expected %h", wb_pkt, m_pkt);
        end
        taken = dut_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (taken[i]) s_v[i] = 1'b0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic set_src(input int s, input int rob, input int data,
                           input logic [1:0] ep, input logic rd);
        logic [31:0] rob32;
        rob32     = rob;
        s_v[s]    = 1'b1;
        s_rob[s]  = rob32[ROB_W-1:0];
        s_prd[s]  = rob32[PHYS_W-1:0] + 7'd8;
        s_data[s] = data;
        s_ep[s]   = ep;
        s_rd[s]   = rd;
        s_pc[s]   = 32'h100 + rob32 * 4;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_v[i] = 1'b0; s_rob[i] = '0; s_prd[i] = '0; s_data[i] = '0;
            s_ep[i] = '0; s_rd[i] = 1'b0; s_pc[i] = '0;
        end
        bru_act_taken = 1'b0; bru_mispredict = 1'b0; bru_redirect_valid = 1'b0;
        bru_redirect_pc = '0; flush_valid = 1'b0; recover_valid = 1'b0;
        recover_epoch = '0; wb_ready = 1'b0;

        // Reset: quiet output for 5 cycles after release.
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_wb_valid", wb_valid, 1'b0);
            chk("reset_wb_pkt_zero", (wb_pkt == '0), 1'b1);
        end

        // Simultaneous valids: ALU, BRU, LSU on consecutive cycles.
        wb_ready = 1'b1;
        set_src(0, 3, 32'h11, 2'd0, 1'b1);
        set_src(1, 4, 32'h22, 2'd0, 1'b1);
        bru_act_taken = 1'b1;
        set_src(2, 5, 32'h33, 2'd0, 1'b0);
        #1 chk("simul_grant_alu", dut_rdy, 3'b001);
        tick();
        chk("simul_alu_valid", wb_valid, 1'b1);
        chk("simul_alu_rob", wb_pkt.rob_idx, 3);
        chk("simul_alu_data", wb_pkt.data, 32'h11);
        tick();
        chk("simul_bru_rob", wb_pkt.rob_idx, 4);
        chk("simul_bru_taken", wb_pkt.act_taken, 1'b1);
        tick();
        chk("simul_lsu_rob", wb_pkt.rob_idx, 5);
        chk("simul_lsu_data_valid", wb_pkt.data_valid, 1'b0);
        tick();
        chk("simul_drain", wb_valid, 1'b0);

        // Backpressure: output full, ALU must wait, payload held.
        wb_ready = 1'b0;
        bru_act_taken = 1'b0;
        set_src(0, 7, 32'h55, 2'd0, 1'b1);
        tick();
        chk("bp_first_rob", wb_pkt.rob_idx, 7);
        set_src(0, 8, 32'h66, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("bp_alu_ready_low", alu_wb_ready, 1'b0);
            tick();
            chk("bp_pkt_held", wb_pkt.data, 32'h55);
        end
        wb_ready = 1'b1;
        #1 chk("bp_alu_ready_high", alu_wb_ready, 1'b1);
        tick();
        chk("bp_second_rob", wb_pkt.rob_idx, 8);
        chk("bp_second_data", wb_pkt.data, 32'h66);
        tick();
        chk("bp_drain", wb_valid, 1'b0);

        // BRU sideband, then an ALU packet must carry none of it.
        bru_mispredict = 1'b1; bru_redirect_valid = 1'b1;
        bru_redirect_pc = 32'h400; bru_act_taken = 1'b1;
        set_src(1, 9, 32'h77, 2'd0, 1'b0);
        tick();
        chk("bru_mispredict", wb_pkt.mispredict, 1'b1);
        chk("bru_redirect_pc", wb_pkt.redirect_pc, 32'h400);
        chk("bru_redirect_valid", wb_pkt.redirect_valid, 1'b1);
        set_src(0, 10, 32'h88, 2'd0, 1'b1);
        tick();
        chk("alu_after_bru_rob", wb_pkt.rob_idx, 10);
        chk("alu_no_redirect_pc", wb_pkt.redirect_pc, 32'h0);
        chk("alu_no_mispredict", wb_pkt.mispredict, 1'b0);

        // Recover to epoch 1 with an epoch-0 packet buffered.
        wb_ready = 1'b0;
        recover_valid = 1'b1; recover_epoch = 2'd1;
        tick();
        recover_valid = 1'b0;
        chk("recover_drops_out", wb_valid, 1'b0);
        wb_ready = 1'b1;
        set_src(2, 11, 32'haa, 2'd0, 1'b1);
        #1 chk("recover_stale_sink", lsu_wb_ready, 1'b1);
        tick();
        chk("recover_stale_no_out", wb_valid, 1'b0);
        set_src(2, 12, 32'h99, 2'd1, 1'b1);
        tick();
        chk("recover_live_valid", wb_valid, 1'b1);
        chk("recover_live_rob", wb_pkt.rob_idx, 12);
        chk("recover_live_epoch", wb_pkt.epoch, 2'd1);

        // Flush with all sources valid.
        set_src(0, 13, 32'h13, 2'd1, 1'b1);
        set_src(1, 14, 32'h14, 2'd1, 1'b1);
        set_src(2, 15, 32'h15, 2'd1, 1'b1);
        flush_valid = 1'b1;
        #1 chk("flush_readies_low", dut_rdy, 3'b000);
        tick();
        flush_valid = 1'b0;
        chk("flush_out_cleared", wb_valid, 1'b0);
        tick();
        chk("post_flush_alu", wb_pkt.rob_idx, 13);
        tick();
        chk("post_flush_bru", wb_pkt.rob_idx, 14);
        tick();
        chk("post_flush_lsu", wb_pkt.rob_idx, 15);
        tick();

        // Stale sink while full, then same-cycle recover arbitration.
        wb_ready = 1'b0;
        set_src(0, 16, 32'h16, 2'd1, 1'b1);
        tick();
        set_src(1, 17, 32'h17, 2'd0, 1'b1);
        #1 chk("full_stale_sink", dut_rdy, 3'b010);
        tick();
        chk("full_pkt_held", wb_pkt.rob_idx, 16);
        wb_ready = 1'b1;
        recover_valid = 1'b1; recover_epoch = 2'd2;
        set_src(2, 18, 32'h18, 2'd2, 1'b1);
        #1 chk("recover_same_cycle_grant", lsu_wb_ready, 1'b1);
        tick();
        recover_valid = 1'b0;
        chk("recover_same_cycle_rob", wb_pkt.rob_idx, 18);

        // Flush and recover together: flush drops output, epoch still moves.
        flush_valid = 1'b1; recover_valid = 1'b1; recover_epoch = 2'd3;
        set_src(0, 19, 32'h19, 2'd3, 1'b1);
        #1 chk("flush_recover_readies", dut_rdy, 3'b000);
        tick();
        flush_valid = 1'b0; recover_valid = 1'b0;
        chk("flush_recover_out", wb_valid, 1'b0);
        tick();
        chk("flush_recover_epoch_live", wb_pkt.rob_idx, 19);

        // Reset mid-operation loses the buffered packet.
        wb_ready = 1'b0;
        rst_n = 1'b0;
        set_src(1, 20, 32'h20, 2'd0, 1'b1);
        #1 chk("midreset_out", wb_valid, 1'b0);
        chk("midreset_readies", dut_rdy, 3'b000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("midreset_replay_rob", wb_pkt.rob_idx, 20);
        wb_ready = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that sits directly downstream of the ALU, BRU and LSU function units. It merges their three independent writeback streams into one registered `fu_wb_t` packet per cycle for the ROB, the PRF and the RS wakeup path. It applies round-robin fairness across the units, carries the BRU branch-resolution sideband, and discards packets from squashed epochs so stale results never reach the ROB or PRF.

## Interface
Parameters:
- `ROB_W`, default `ROB_W` (package), ROB index width.
- `PHYS_W`, default `PHYS_W` (package), physical register index width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `{alu,bru,lsu}_wb_valid`  in  1  source packet valid.
- `{alu,bru,lsu}_wb_ready`  out  1  packet consumed this cycle.
- `{alu,bru,lsu}_wb_rob_idx`  in  ROB_W.
- `{alu,bru,lsu}_wb_prd_new`  in  PHYS_W.
- `{alu,bru,lsu}_wb_data`  in  32.
- `{alu,bru,lsu}_wb_epoch`  in  2.
- `{alu,bru,lsu}_wb_uses_rd`  in  1.
- `{alu,bru,lsu}_wb_pc`  in  32.
- `bru_act_taken`, `bru_mispredict`, `bru_redirect_valid`  in  1  BRU sideband, qualified by `bru_wb_valid`.
- `bru_redirect_pc`  in  32  BRU redirect target.
- `flush_valid`  in  1  full pipeline flush.
- `recover_valid`  in  1  mispredict recovery.
- `recover_epoch`  in  2  epoch that becomes current after recovery.
- `wb_valid`  out  1  registered output packet valid.
- `wb_ready`  in  1  downstream accept.
- `wb_pkt`  out  fu_wb_t  registered output packet.

## Operation
- **Output register and source index.** The block holds one output register `{out_v, out_pkt}`. `wb_valid` is `out_v` and `wb_pkt` is `out_pkt`. Source index order is ALU=0, BRU=1, LSU=2.
- **Current epoch.** `cur_epoch` (2 bits) resets to 0 and loads `recover_epoch` when `recover_valid` is high. A source packet is stale when its epoch differs from `cur_epoch`.
- **Stale sinking.** A stale source packet gets ready=1 in the same cycle, regardless of grant or output state, and is then dropped. Sinking stale packets does not advance the round-robin pointer.
- **Capture enable.** `cap_ok = ~out_v | wb_ready`.
- **Arbitration.** Among non-stale valid sources, pick the first one at or after `rr_ptr`, wrapping modulo 3. The grantee gets ready = `cap_ok`.
- **Capture.** On capture, load `out_pkt` from the grantee and set `data_valid = uses_rd`. BRU sideband fields are copied only when the grantee is BRU; otherwise they are zero. After capture, `rr_ptr` becomes grantee+1 mod 3.
- **Pop without refill.** If `wb_ready && out_v` and nothing is captured, clear `out_v`.
- **Flush.** `flush_valid` clears `out_v`, forces all source readies to 0 that cycle, and captures nothing. `cur_epoch` and `rr_ptr` are unchanged.
- **Recover.** `recover_valid` clears `out_v` if `out_pkt.epoch != recover_epoch`. Arbitration in that same cycle compares against `recover_epoch`, not the old `cur_epoch`.
- **Flush and recover together.** Flush wins for the output register. `cur_epoch` still updates.

## Timing
- **Latency.** Source handshake in cycle N gives `wb_valid` in N+1. With `wb_ready` held high, throughput is one packet per cycle.
- **Ready path.** Source readies are combinational from valids, `out_v`, `wb_ready`, `rr_ptr`, `flush_valid` and `recover_*`. There is no combinational path from any source valid to `wb_valid`.
- **Hold rule.** `wb_pkt` is held stable while `wb_valid && !wb_ready`.
- **Reset values.** `out_v=0`, `out_pkt='0`, `rr_ptr=0`, `cur_epoch=0`. With `rst_n` low, all readies are 0.
- **Reset mid-operation.** The buffered packet is lost. Sources must re-present.
- **Full.** When `out_v` is high and `wb_ready` is low, grant readies are 0. Stale packets are still sunk.
- **Simultaneous valids.** Exactly one grant per cycle. No source waits more than two captures.

## Structure
- `fu_wb_t` and `ROB_W`, `PHYS_W` come from the shared package via `defines.svh`.
- Add a `wb_src_e` enum (ALU/BRU/LSU) to that package.
- One sub-module: `rr_arb3`, a combinational 3-way round-robin grant from `req[2:0]` and `ptr` giving a one-hot grant. The pointer register stays in `wb_arbiter`.
- Total RTL is about 180 lines.

## Test plan
- **Reset.** Release `rst_n`, all valids 0 → `wb_valid=0` and `wb_pkt=0` for 5 cycles.
- **Simultaneous valids.** ALU, BRU and LSU all valid at epoch 0, `wb_ready=1` → outputs in order ALU, BRU, LSU on consecutive cycles. The ALU packet (`rob_idx=3`, `data=0x11`) appears in cycle N+1.
- **Backpressure.** `wb_ready=0` for 4 cycles with ALU valid → `alu_wb_ready=0` and `wb_pkt` unchanged. Raise `wb_ready` → ALU is consumed the next cycle.
- **BRU sideband.** BRU packet with `mispredict=1`, `redirect_pc=0x400` → `wb_pkt` carries both. A following ALU packet has redirect fields equal to 0.
- **Recover.** Recover to epoch 1 while `out_pkt.epoch=0` → `wb_valid=0` next cycle. LSU valid with epoch 0 → `lsu_wb_ready=1` and no output. LSU valid with epoch 1 → output.
- **Flush.** Flush with all sources valid → all readies 0 that cycle and `wb_valid=0` next cycle.
